// File: rtl/blc_pkg.sv
// Shared black-level-correction definitions: default pixel width and the
// layout of a buffered line entry {sof, eol, data}.
package blc_pkg;

  localparam int BLC_DATA_WIDTH  = 8;
  localparam int BLC_ENTRY_WIDTH = BLC_DATA_WIDTH + 2;
  localparam int BLC_EOL_BIT     = BLC_DATA_WIDTH;
  localparam int BLC_SOF_BIT     = BLC_DATA_WIDTH + 1;

  // Entry layout helpers for a non-default pixel width
  function automatic int blc_entry_width(input int dw);
    return dw + 2;
  endfunction

  function automatic int blc_eol_bit(input int dw);
    return dw;
  endfunction

  function automatic int blc_sof_bit(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/blc_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with full/empty/count.
// The head entry is visible on rdata whenever the FIFO is not empty.
module blc_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/blc_line_fifo.sv
// Line buffer after black-level correction: tags pixels with start-of-frame
// and end-of-line, buffers them in an FWFT FIFO, and paces the upstream
// stage with single-cycle credit requests. Overflow is sticky until flush.
module blc_line_fifo
  import blc_pkg::*;
#(
  parameter int DATA_WIDTH = BLC_DATA_WIDTH,
  parameter int READ_PIXEL = 16,
  parameter int LINES      = 8,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] idata,
  output logic                  o_req,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  o_sof,
  output logic                  o_eol,
  output logic                  o_ovf
);

  localparam int EW    = blc_entry_width(DATA_WIDTH);
  localparam int SOF_B = blc_sof_bit(DATA_WIDTH);
  localparam int EOL_B = blc_eol_bit(DATA_WIDTH);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (READ_PIXEL > 1) ? $clog2(READ_PIXEL) : 1;
  localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;

  localparam logic [CW-1:0] LAST_COL  = CW'(READ_PIXEL - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);
  localparam logic [AW+1:0] CREDIT_LIMIT = (AW + 2)'(DEPTH);

  logic [EW-1:0] wentry;
  logic [EW-1:0] rentry;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic [AW:0]   outstanding;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic          pop;
  logic          push_ok;
  logic          credit_ok;

  assign pop       = !empty && i_ready && !i_flush;
  assign push_ok   = i_valid && !i_flush && (!full || pop);
  assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < CREDIT_LIMIT;

  assign o_valid = !empty;
  assign odata   = rentry[DATA_WIDTH-1:0];
  assign o_sof   = rentry[SOF_B];
  assign o_eol   = rentry[EOL_B];

  // Build the stored entry: framing tags above the pixel
  always_comb begin
    wentry                   = '0;
    wentry[DATA_WIDTH-1:0]   = idata;
    wentry[SOF_B]            = (col == '0) && (line == '0);
    wentry[EOL_B]            = (col == LAST_COL);
  end

  blc_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (i_flush),
    .push  (push_ok),
    .pop   (pop),
    .wdata (wentry),
    .rdata (rentry),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  // Column/line position of the next accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      line <= '0;
    end else if (i_flush) begin
      col  <= '0;
      line <= '0;
    end else if (push_ok) begin
      if (col == LAST_COL) begin
        col  <= '0;
        line <= (line == LAST_LINE) ? '0 : line + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Credit request pulse with a mandatory low cycle between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_req <= 1'b0;
    end else if (i_flush) begin
      o_req <= 1'b0;
    end else begin
      o_req <= !o_req && credit_ok;
    end
  end

  // Outstanding credits: up on each request, down on each accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (i_flush) begin
      outstanding <= '0;
    end else if (o_req && !push_ok) begin
      outstanding <= outstanding + 1'b1;
    end else if (!o_req && push_ok && (outstanding != '0)) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // Sticky overflow on a pixel that arrives with no room for it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ovf <= 1'b0;
    end else if (i_flush) begin
      o_ovf <= 1'b0;
    end else if (i_valid && !push_ok) begin
      o_ovf <= 1'b1;
    end
  end

endmodule
